// File: rtl/vp_lvp_table_pkg.sv
// Shared types and helpers for the last-value prediction table.
package vp_lvp_table_pkg;

    // Width of the saturating confidence counters.
    localparam int P_CONF_WIDTH = 3;

    // Widest tag a table entry can hold. A narrower TAG_W is zero-extended into it.
    localparam int LVP_TAG_MAX_W = 30;

    // Training feedback from writeback.
    typedef struct packed {
        logic                    valid;
        logic [30:0]             pc;
        logic [31:0]             actual;
        logic                    misp;
        logic [P_CONF_WIDTH-1:0] conf;
    } vp_fb_pkt_t;

    // Registered predictions toward decode, one set of fields per lane.
    typedef struct packed {
        logic        i0_valid;
        logic [30:0] i0_pc;
        logic [31:0] i0_result;
        logic        i0_conf;
        logic        i0_used;
        logic        i1_valid;
        logic [30:0] i1_pc;
        logic [31:0] i1_result;
        logic        i1_conf;
        logic        i1_used;
    } vp_fw_pkt_t;

    // One table entry.
    typedef struct packed {
        logic                     valid;
        logic [LVP_TAG_MAX_W-1:0] tag;
        logic [31:0]              value;
        logic [P_CONF_WIDTH-1:0]  conf;
    } vp_lvp_entry_t;

    // 32-bit add of a 0..3 increment that sticks at all-ones.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {31'd0, b};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/vp_conf_ctr.sv
// Next-count logic for one saturating confidence counter: clear wins over increment.
module vp_conf_ctr
    import vp_lvp_table_pkg::*;
(
    input  logic [P_CONF_WIDTH-1:0] cnt,
    input  logic                    inc,
    input  logic                    clr,
    output logic [P_CONF_WIDTH-1:0] nxt
);

    // Compute the next counter value, holding at all-ones.
    always_comb begin
        nxt = cnt;
        if (clr) begin
            nxt = {P_CONF_WIDTH{1'b0}};
        end else if (inc && (cnt != {P_CONF_WIDTH{1'b1}})) begin
            nxt = cnt + {{(P_CONF_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            nxt = cnt;
        end
    end

endmodule

// File: rtl/vp_lvp_table.sv
// Direct-mapped, tagged last-value prediction table with two lookup lanes,
// one training port, write-first bypass and a registered forward packet.
module vp_lvp_table
    import vp_lvp_table_pkg::*;
#(
    parameter int ENTRIES     = 64,
    parameter int TAG_W       = 8,
    parameter int CONF_THRESH = (1 << P_CONF_WIDTH) - 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i0_lookup_valid,
    input  logic [30:0] i0_lookup_pc,
    input  logic        i1_lookup_valid,
    input  logic [30:0] i1_lookup_pc,
    input  logic        flush,
    input  logic        invalidate_all,
    input  vp_fb_pkt_t  vp_fb_pkt,
    output vp_fw_pkt_t  vp_fw_pkt,
    output logic [31:0] stat_pred_cnt,
    output logic [31:0] stat_misp_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [P_CONF_WIDTH-1:0] THRESH_C = P_CONF_WIDTH'(CONF_THRESH);

    vp_lvp_entry_t table_r [ENTRIES];

    // Feedback side
    logic [IDX_W-1:0]         fb_idx_s;
    logic [LVP_TAG_MAX_W-1:0] fb_tag_s;
    vp_lvp_entry_t            fb_old_s;
    vp_lvp_entry_t            fb_new_s;
    logic                     fb_hit_s;
    logic                     fb_match_s;
    logic                     fb_clr_s;
    logic [P_CONF_WIDTH-1:0]  conf_nxt_s;

    // Lookup side, lane 0 and lane 1
    logic [IDX_W-1:0]         lk_idx_s    [2];
    logic [LVP_TAG_MAX_W-1:0] lk_tag_s    [2];
    logic [30:0]              lk_pc_s     [2];
    logic                     lk_valid_s  [2];
    vp_lvp_entry_t            lk_ent_s    [2];
    logic                     lk_hit_s    [2];
    logic [31:0]              lk_result_s [2];
    logic                     lk_conf_s   [2];

    vp_fw_pkt_t  pkt_r;
    logic [31:0] pred_cnt_r;
    logic [31:0] misp_cnt_r;
    logic [1:0]  pred_add_s;
    logic        unused_s;

    // PC bits above the tag and the feedback confidence play no part in the table.
    assign unused_s = ^{vp_fb_pkt.conf, vp_fb_pkt.pc};

    assign fb_idx_s = vp_fb_pkt.pc[IDX_W-1:0];
    assign fb_tag_s = LVP_TAG_MAX_W'(vp_fb_pkt.pc[IDX_W+TAG_W-1:IDX_W]);
    assign fb_old_s = table_r[fb_idx_s];

    assign lk_pc_s[0]    = i0_lookup_pc;
    assign lk_pc_s[1]    = i1_lookup_pc;
    assign lk_valid_s[0] = i0_lookup_valid;
    assign lk_valid_s[1] = i1_lookup_valid;

    // Classify the feedback against the stored entry: only an exact, non-mispredicted repeat builds confidence.
    always_comb begin
        fb_hit_s   = fb_old_s.valid && (fb_old_s.tag == fb_tag_s);
        fb_match_s = fb_hit_s && !vp_fb_pkt.misp && (vp_fb_pkt.actual == fb_old_s.value);
        fb_clr_s   = !fb_match_s;
    end

    vp_conf_ctr u_conf_ctr (
        .cnt (fb_old_s.conf),
        .inc (fb_match_s),
        .clr (fb_clr_s),
        .nxt (conf_nxt_s)
    );

    // Post-training entry; on a match actual equals the stored value, so the value is always actual.
    always_comb begin
        fb_new_s       = fb_old_s;
        fb_new_s.valid = 1'b1;
        fb_new_s.tag   = fb_tag_s;
        fb_new_s.value = vp_fb_pkt.actual;
        fb_new_s.conf  = conf_nxt_s;
    end

    // Per-lane lookup with invalidate and same-index write-first bypass applied.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            lk_idx_s[l] = lk_pc_s[l][IDX_W-1:0];
            lk_tag_s[l] = LVP_TAG_MAX_W'(lk_pc_s[l][IDX_W+TAG_W-1:IDX_W]);
            lk_ent_s[l] = table_r[lk_idx_s[l]];
            if (invalidate_all) begin
                lk_ent_s[l].valid = 1'b0;
            end else if (vp_fb_pkt.valid && (lk_idx_s[l] == fb_idx_s)) begin
                lk_ent_s[l] = fb_new_s;
            end else begin
                lk_ent_s[l] = table_r[lk_idx_s[l]];
            end
            lk_hit_s[l]    = lk_ent_s[l].valid && (lk_ent_s[l].tag == lk_tag_s[l]);
            lk_result_s[l] = lk_hit_s[l] ? lk_ent_s[l].value : 32'd0;
            lk_conf_s[l]   = lk_hit_s[l] && (lk_ent_s[l].conf >= THRESH_C);
        end
    end

    // Confident predictions carried by a packet that is actually issued.
    always_comb begin
        pred_add_s = 2'd0;
        if (flush) begin
            pred_add_s = 2'd0;
        end else begin
            pred_add_s = {1'b0, lk_valid_s[0] && lk_conf_s[0]}
                       + {1'b0, lk_valid_s[1] && lk_conf_s[1]};
        end
    end

    // Table storage: invalidate beats training; one entry written per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                table_r[e] <= '0;
            end
        end else if (invalidate_all) begin
            for (int e = 0; e < ENTRIES; e++) begin
                table_r[e].valid <= 1'b0;
            end
        end else if (vp_fb_pkt.valid) begin
            table_r[fb_idx_s] <= fb_new_s;
        end
    end

    // Forward packet register; a flush issues an all-invalid packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_r <= '0;
        end else if (flush) begin
            pkt_r <= '0;
        end else begin
            pkt_r.i0_valid  <= i0_lookup_valid;
            pkt_r.i0_pc     <= i0_lookup_pc;
            pkt_r.i0_result <= lk_result_s[0];
            pkt_r.i0_conf   <= lk_conf_s[0];
            pkt_r.i0_used   <= 1'b0;
            pkt_r.i1_valid  <= i1_lookup_valid;
            pkt_r.i1_pc     <= i1_lookup_pc;
            pkt_r.i1_result <= lk_result_s[1];
            pkt_r.i1_conf   <= lk_conf_s[1];
            pkt_r.i1_used   <= 1'b0;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_cnt_r <= 32'd0;
            misp_cnt_r <= 32'd0;
        end else begin
            pred_cnt_r <= sat_add32(pred_cnt_r, pred_add_s);
            if (vp_fb_pkt.valid && vp_fb_pkt.misp) begin
                misp_cnt_r <= sat_add32(misp_cnt_r, 2'd1);
            end
        end
    end

    assign vp_fw_pkt     = pkt_r;
    assign stat_pred_cnt = pred_cnt_r;
    assign stat_misp_cnt = misp_cnt_r;

endmodule

// File: tb/tb_vp_lvp_table.sv
// Directed bench for vp_lvp_table: stimulus pushes expected packets into a
// queue and a negedge monitor pops and compares every valid forward packet.
module tb_vp_lvp_table;
    import vp_lvp_table_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i0_lookup_valid;
    logic [30:0] i0_lookup_pc;
    logic        i1_lookup_valid;
    logic [30:0] i1_lookup_pc;
    logic        flush;
    logic        invalidate_all;
    vp_fb_pkt_t  vp_fb_pkt;
    vp_fw_pkt_t  vp_fw_pkt;
    logic [31:0] stat_pred_cnt;
    logic [31:0] stat_misp_cnt;

    typedef struct {
        logic        v0;
        logic [30:0] p0;
        logic [31:0] r0;
        logic        c0;
        logic        v1;
        logic [30:0] p1;
        logic [31:0] r1;
        logic        c1;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    exp_t mon_e;
    logic mon_ok;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vp_lvp_table dut (
        .clk             (clk),
        .rst             (rst),
        .i0_lookup_valid (i0_lookup_valid),
        .i0_lookup_pc    (i0_lookup_pc),
        .i1_lookup_valid (i1_lookup_valid),
        .i1_lookup_pc    (i1_lookup_pc),
        .flush           (flush),
        .invalidate_all  (invalidate_all),
        .vp_fb_pkt       (vp_fb_pkt),
        .vp_fw_pkt       (vp_fw_pkt),
        .stat_pred_cnt   (stat_pred_cnt),
        .stat_misp_cnt   (stat_misp_cnt)
    );

    // Monitor: every valid forward packet must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (vp_fw_pkt.i0_valid || vp_fw_pkt.i1_valid)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pkt: got v0=%0b r0=%h v1=%0b r1=%h, required no packet",
                         vp_fw_pkt.i0_valid, vp_fw_pkt.i0_result, vp_fw_pkt.i1_valid, vp_fw_pkt.i1_result);
            end else begin
                mon_e  = q.pop_front();
                mon_ok = (vp_fw_pkt.i0_valid == mon_e.v0) && (vp_fw_pkt.i1_valid == mon_e.v1)
                      && !vp_fw_pkt.i0_used && !vp_fw_pkt.i1_used;
                if (mon_e.v0) begin
                    mon_ok = mon_ok && (vp_fw_pkt.i0_pc == mon_e.p0)
                          && (vp_fw_pkt.i0_result == mon_e.r0) && (vp_fw_pkt.i0_conf == mon_e.c0);
                end
                if (mon_e.v1) begin
                    mon_ok = mon_ok && (vp_fw_pkt.i1_pc == mon_e.p1)
                          && (vp_fw_pkt.i1_result == mon_e.r1) && (vp_fw_pkt.i1_conf == mon_e.c1);
                end
                if (!mon_ok) begin
                    bad++;
                    $display("FAIL fw_pkt: got v0=%0b pc0=%h r0=%h c0=%0b u0=%0b v1=%0b pc1=%h r1=%h c1=%0b u1=%0b; required v0=%0b pc0=%h r0=%h c0=%0b v1=%0b pc1=%h r1=%h c1=%0b",
                             vp_fw_pkt.i0_valid, vp_fw_pkt.i0_pc, vp_fw_pkt.i0_result, vp_fw_pkt.i0_conf, vp_fw_pkt.i0_used,
                             vp_fw_pkt.i1_valid, vp_fw_pkt.i1_pc, vp_fw_pkt.i1_result, vp_fw_pkt.i1_conf, vp_fw_pkt.i1_used,
                             mon_e.v0, mon_e.p0, mon_e.r0, mon_e.c0, mon_e.v1, mon_e.p1, mon_e.r1, mon_e.c1);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i0_lookup_valid = 1'b0;
        i0_lookup_pc    = 31'd0;
        i1_lookup_valid = 1'b0;
        i1_lookup_pc    = 31'd0;
        flush           = 1'b0;
        invalidate_all  = 1'b0;
        vp_fb_pkt       = '0;
        pend.v0 = 1'b0; pend.p0 = 31'd0; pend.r0 = 32'd0; pend.c0 = 1'b0;
        pend.v1 = 1'b0; pend.p1 = 31'd0; pend.r1 = 32'd0; pend.c1 = 1'b0;
    endtask

    // Lookup on a lane with its hand-computed expected result and confidence.
    task automatic look(input int lane, input logic [31:0] addr, input logic [31:0] r, input logic c);
        if (lane == 0) begin
            i0_lookup_valid = 1'b1;
            i0_lookup_pc    = addr[31:1];
            pend.v0 = 1'b1; pend.p0 = addr[31:1]; pend.r0 = r; pend.c0 = c;
        end else begin
            i1_lookup_valid = 1'b1;
            i1_lookup_pc    = addr[31:1];
            pend.v1 = 1'b1; pend.p1 = addr[31:1]; pend.r1 = r; pend.c1 = c;
        end
    endtask

    task automatic fb(input logic [31:0] addr, input logic [31:0] act, input logic misp);
        vp_fb_pkt.valid  = 1'b1;
        vp_fb_pkt.pc     = addr[31:1];
        vp_fb_pkt.actual = act;
        vp_fb_pkt.misp   = misp;
        vp_fb_pkt.conf   = 3'd5;
    endtask

    // Issue the current cycle's inputs and advance to just after the next edge.
    task automatic tick();
        if ((pend.v0 || pend.v1) && !flush) begin
            q.push_back(pend);
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pkt_zero", {31'd0, vp_fw_pkt != '0}, 32'd0);
        chk("rst_pred_cnt", stat_pred_cnt, 32'd0);
        chk("rst_misp_cnt", stat_misp_cnt, 32'd0);
        rst = 1'b0;

        // First lookup after reset misses.
        look(0, 32'h0000_1000, 32'd0, 1'b0); tick();

        // Allocation plus six increments: conf 6, still below threshold 7.
        for (int i = 0; i < 7; i++) begin
            fb(32'h0000_1000, 32'hDEAD_BEEF, 1'b0); tick();
        end
        look(0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0); tick();
        chk("pred_cnt_conf6", stat_pred_cnt, 32'd0);

        // Seventh increment reaches threshold.
        fb(32'h0000_1000, 32'hDEAD_BEEF, 1'b0); tick();
        look(0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1); tick();
        chk("pred_cnt_first", stat_pred_cnt, 32'd1);

        // Both lanes on the same index get identical confident results.
        look(0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        look(1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1); tick();
        chk("pred_cnt_dual", stat_pred_cnt, 32'd3);

        // Mispredict replaces value and clears confidence.
        fb(32'h0000_1000, 32'h0000_0005, 1'b1); tick();
        chk("misp_cnt_one", stat_misp_cnt, 32'd1);
        look(0, 32'h0000_1000, 32'h0000_0005, 1'b0); tick();

        // Value change without misp also retrains.
        fb(32'h0000_1000, 32'h0000_0005, 1'b0); tick();
        fb(32'h0000_1000, 32'h0000_0009, 1'b0); tick();
        look(1, 32'h0000_1000, 32'h0000_0009, 1'b0); tick();
        chk("misp_cnt_hold", stat_misp_cnt, 32'd1);

        // Same-cycle bypass: 0x2000 aliases 0x1000's index with another tag.
        fb(32'h0000_2000, 32'h0000_1234, 1'b0);
        look(0, 32'h0000_2000, 32'h0000_1234, 1'b0);
        look(1, 32'h0000_1000, 32'd0, 1'b0); tick();
        look(0, 32'h0000_1000, 32'd0, 1'b0);
        look(1, 32'h0000_2000, 32'h0000_1234, 1'b0); tick();

        // Train 0x2000 to confidence; the last increment is seen via bypass.
        for (int i = 0; i < 6; i++) begin
            fb(32'h0000_2000, 32'h0000_1234, 1'b0); tick();
        end
        fb(32'h0000_2000, 32'h0000_1234, 1'b0);
        look(0, 32'h0000_2000, 32'h0000_1234, 1'b1); tick();
        chk("pred_cnt_bypass", stat_pred_cnt, 32'd4);

        // Flushed confident lookups produce no packet and no count.
        flush = 1'b1;
        look(0, 32'h0000_2000, 32'h0000_1234, 1'b1);
        look(1, 32'h0000_2000, 32'h0000_1234, 1'b1); tick();
        chk("pred_cnt_flush", stat_pred_cnt, 32'd4);
        look(0, 32'h0000_2000, 32'h0000_1234, 1'b1);
        look(1, 32'h0000_2000, 32'h0000_1234, 1'b1); tick();
        chk("pred_cnt_after_flush", stat_pred_cnt, 32'd6);

        // Second index.
        fb(32'h0000_1004, 32'h0000_0077, 1'b0); tick();
        look(0, 32'h0000_1004, 32'h0000_0077, 1'b0); tick();

        // Invalidate beats same-cycle training and same-cycle lookups miss.
        invalidate_all = 1'b1;
        fb(32'h0000_1004, 32'h0000_0099, 1'b0);
        look(0, 32'h0000_2000, 32'd0, 1'b0);
        look(1, 32'h0000_1004, 32'd0, 1'b0); tick();
        look(0, 32'h0000_2000, 32'd0, 1'b0);
        look(1, 32'h0000_1004, 32'd0, 1'b0); tick();
        chk("pred_cnt_inval", stat_pred_cnt, 32'd6);

        // Retrain, then asynchronous reset mid-cycle clears everything at once.
        fb(32'h0000_1000, 32'h0000_0042, 1'b0); tick();
        look(0, 32'h0000_1000, 32'h0000_0042, 1'b0); tick();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_pkt", {31'd0, vp_fw_pkt != '0}, 32'd0);
        chk("async_rst_pred", stat_pred_cnt, 32'd0);
        chk("async_rst_misp", stat_misp_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After release the trained entry is gone.
        look(0, 32'h0000_1000, 32'd0, 1'b0); tick();
        look(1, 32'h0000_2000, 32'd0, 1'b0); tick();
        tick();
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
